// File: rtl/mem_test_pkg.sv
// Shared types and constants for the SDRAM memory test driver.
// Optional build macro: TIMEOUT_EN (request watchdog, see mem_test_driver).
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WGAP  = 3'd2,
    READ  = 3'd3,
    RGAP  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Pattern select encodings, latched at start.
  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_ALT  = 2'd3;

  // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1, shifting toward bit 0.
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/mem_test_pattern.sv
// Pattern generator shared by the write and compare paths so both see
// identical data for a given address and LFSR position. Holds the LFSR.
module mem_test_pattern
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] bit_idx;
  logic [DATA_W-1:0] walk;
  logic [DATA_W-1:0] lfsr_rep;

  // LFSR next value: reseed wins over a step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Pattern for the current address / LFSR position in the latched mode.
  always_comb begin
    bit_idx  = address % ADDR_W'(DATA_W);
    walk     = '0;
    lfsr_rep = '0;
    for (int i = 0; i < DATA_W; i++) begin
      walk[i]     = (bit_idx == ADDR_W'(i));
      lfsr_rep[i] = lfsr_q[5'(i % 32)];
    end
    pattern = '0;
    unique case (mode)
      MODE_ADDR: pattern = DATA_W'(address);
      MODE_LFSR: pattern = lfsr_rep;
      MODE_WALK: pattern = walk;
      MODE_ALT:  pattern = address[0] ? '0 : '1;
    endcase
  end

endmodule

// File: rtl/mem_test_driver.sv
// SDRAM traffic generator / self-checker on the controller user side.
// A button press writes a pattern over [START_ADDR, END_ADDR] in ADDR_STEP
// strides, reads it back and compares every word.
// Optional build macro: TIMEOUT_EN adds a request watchdog and a timeout port.
//
// Handshake: req_write / req_read are levels. Each stays high, with address
// and data_in held stable, until the controller returns a one-cycle
// write_complete / data_valid pulse; the request drops on that same edge.
// A pulse that does not match the request currently raised is ignored.
module mem_test_driver
  import mem_test_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(24'h00FFFF),
  parameter int unsigned       ADDR_STEP  = 1,
  parameter int                ERR_W      = 16,
  parameter int                LED_W      = 8
`ifdef TIMEOUT_EN
  , parameter int              TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] address,
  output logic              req_read,
  output logic              req_write,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_valid,
  input  logic              write_complete,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [LED_W-1:0]  led,
  output logic [2:0]        dbg_state
`ifdef TIMEOUT_EN
  , output logic            timeout
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        btn_sync_q, btn_sync_d;
  logic              start, last, mismatch, running;
  logic              seed_load, advance;
  logic [DATA_W-1:0] pat;

`ifdef TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic             tmo_q, tmo_d;
`endif

  mem_test_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .advance   (advance),
    .mode      (mode_q),
    .address   (addr_q),
    .pattern   (pat)
  );

  // Two synchroniser stages plus one history bit for rising-edge detection.
  assign btn_sync_d = {btn_sync_q[1:0], button};
  assign start      = btn_sync_q[1] & ~btn_sync_q[2];

  // Computed one bit wider so stepping past the top of the space cannot wrap.
  assign last     = ({1'b0, addr_q} + (ADDR_W+1)'(ADDR_STEP)) > {1'b0, END_ADDR};
  assign mismatch = (data_out != pat);

  // Next-state, address walk, LFSR control and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    fail_d    = fail_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    seed_load = 1'b0;
    advance   = 1'b0;
`ifdef TIMEOUT_EN
    tmo_d     = tmo_q;
    tcnt_d    = '0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = WRITE;
          mode_d    = mode;
          err_d     = 1'b0;
          cnt_d     = '0;
          fail_d    = '0;
          addr_d    = START_ADDR;
          seed_load = 1'b1;
`ifdef TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (write_complete) state_d = WGAP;
      end
      WGAP: begin
        if (last) begin
          addr_d    = START_ADDR;
          seed_load = 1'b1;
          state_d   = READ;
        end else begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          advance = 1'b1;
          state_d = WRITE;
        end
      end
      READ: begin
        if (data_valid) begin
          state_d = RGAP;
          if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!err_q) fail_d = addr_q;
          end
        end
      end
      RGAP: begin
        if (last) begin
          addr_d    = START_ADDR;
          seed_load = 1'b1;
          state_d   = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          advance = 1'b1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TIMEOUT_EN
    // Watchdog: counts cycles a request waits; any completion clears it.
    if ((state_q == WRITE && !write_complete) || (state_q == READ && !data_valid)) begin
      if (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
        tmo_d   = 1'b1;
        if (!err_q) fail_d = addr_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ADDR;
      addr_q     <= START_ADDR;
      fail_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      btn_sync_q <= '0;
`ifdef TIMEOUT_EN
      tcnt_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      btn_sync_q <= btn_sync_d;
`ifdef TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign running   = (state_q != IDLE) && (state_q != DONE);
  assign address   = addr_q;
  assign req_write = (state_q == WRITE);
  assign req_read  = (state_q == READ);
  assign data_in   = (state_q == WRITE) ? pat : '0;
  assign done      = (state_q == DONE);
  assign error     = err_q;
  assign err_count = cnt_q;
  assign fail_addr = fail_q;
  assign led       = {(LED_W-3)'(cnt_q), err_q, (state_q == DONE), running};
  assign dbg_state = state_q;
`ifdef TIMEOUT_EN
  assign timeout   = tmo_q;
`endif

endmodule

// File: tb/tb_mem_test_driver.sv
// Self-checking bench for mem_test_driver: randomized controller model
// (latencies, spurious pulses, read corruption) against a reference built
// from the pattern rules. Exercises TIMEOUT_EN when that macro is defined.
module tb_mem_test_driver;
  import mem_test_pkg::*;

  localparam int                ADDR_W     = 8;
  localparam int                DATA_W     = 32;
  localparam logic [ADDR_W-1:0] START_ADDR = 8'hC0;
  localparam logic [ADDR_W-1:0] END_ADDR   = 8'hFF;
  localparam int                ADDR_STEP  = 3;
  localparam int                ERR_W      = 4;
  localparam int                LED_W      = 8;
  localparam int                N_WORDS    = (int'(END_ADDR) - int'(START_ADDR)) / ADDR_STEP + 1;
  localparam int                CNT_MAX    = (1 << ERR_W) - 1;
  localparam int RD_OK = 0, RD_FLIP = 1, RD_ZERO = 2, RD_HANG = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              button = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [ADDR_W-1:0] address;
  logic              req_read, req_write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, write_complete;
  logic              done, error;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [LED_W-1:0]  led;
  logic [2:0]        dbg_state;
`ifdef TIMEOUT_EN
  logic              timeout;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  mem_test_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR),
    .ADDR_STEP(ADDR_STEP), .ERR_W(ERR_W), .LED_W(LED_W)
`ifdef TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .address(address),
    .req_read(req_read), .req_write(req_write), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .write_complete(write_complete),
    .done(done), .error(error), .err_count(err_count), .fail_addr(fail_addr),
    .led(led), .dbg_state(dbg_state)
`ifdef TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Scoreboard state (written by the main sequence only)
  logic [DATA_W-1:0] exp_q[$];
  int                run_id = 0;
  int                rd_mode = RD_OK;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  int                spur_req = 0;
  logic              exp_err;
  int                exp_cnt;
  logic [ADDR_W-1:0] exp_fail;

  // Controller-model observations (written by the model only)
  int wr_idx = 0, rd_idx = 0;
  int wr_errs = 0, rd_errs = 0, proto_errs = 0, clr_errs = 0;
  logic [DATA_W-1:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [ADDR_W-1:0] exp_addr(input int k);
    return ADDR_W'(int'(START_ADDR) + k * ADDR_STEP);
  endfunction

  // Galois step for x^32+x^22+x^2+x+1: shift down, fold the dropped bit back.
  function automatic logic [31:0] galois(input logic [31:0] x);
    logic fb;
    fb = x[0];
    x  = x >> 1;
    if (fb) x = x ^ 32'h8020_0003;
    return x;
  endfunction

  function automatic logic [DATA_W-1:0] ref_pattern(input int k, input logic [1:0] m);
    int          a;
    logic [31:0] x;
    a = int'(START_ADDR) + k * ADDR_STEP;
    case (m)
      MODE_ADDR: return DATA_W'(a);
      MODE_LFSR: begin
        x = 32'h1;
        repeat (k) x = galois(x);
        return x;
      end
      MODE_WALK: return DATA_W'(1) << (a % DATA_W);
      default:   return (a % 2 == 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    endcase
  endfunction

  // Builds expected write data and the expected error outcome of a run.
  task automatic plan_run(input logic [1:0] m, input int rdm);
    int                k_bad;
    logic [DATA_W-1:0] ret;
    exp_q.delete();
    for (int k = 0; k < N_WORDS; k++) exp_q.push_back(ref_pattern(k, m));
    k_bad        = $urandom_range(0, N_WORDS - 1);
    corrupt_addr = exp_addr(k_bad);
    rd_mode      = rdm;
    mode         = m;
    exp_err      = 1'b0;
    exp_cnt      = 0;
    exp_fail     = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      ret = (rdm == RD_ZERO) ? '0 : (exp_q[k] ^ ((rdm == RD_FLIP && k == k_bad) ? 32'h1 : 32'h0));
      if (ret != exp_q[k]) begin
        if (!exp_err) exp_fail = exp_addr(k);
        exp_err = 1'b1;
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
    run_id++;
  endtask

  // Controller model: random latencies, spurious pulses, memory, protocol watch.
  initial begin : ctrl_model
    int                wr_busy, rd_busy, wr_lat, rd_lat, seen_run, spur_done;
    logic              prev_req;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    wr_busy = 0; rd_busy = 0; wr_lat = 1; rd_lat = 1; seen_run = -1; spur_done = 0;
    prev_req = 1'b0; prev_addr = '0; prev_data = '0;
    write_complete = 1'b0; data_valid = 1'b0; data_out = '0;
    forever begin
      @(negedge clk);
      write_complete = 1'b0;
      data_valid     = 1'b0;
      if (seen_run != run_id) begin
        seen_run = run_id; wr_idx = 0; rd_idx = 0;
      end
      if (rst) begin
        wr_busy = 0; rd_busy = 0; prev_req = 1'b0;
        continue;
      end
      if (req_read && req_write) proto_errs++;
      if (prev_req && (req_read || req_write) && (address !== prev_addr || data_in !== prev_data))
        proto_errs++;
      prev_req = req_read || req_write; prev_addr = address; prev_data = data_in;

      if (spur_done != spur_req) begin
        spur_done = spur_req;
        write_complete = 1'b1;
      end else if (req_write) begin
        if (wr_busy == 0) wr_lat = $urandom_range(1, 4);
        wr_busy++;
        if (wr_busy >= wr_lat) begin
          wr_busy = 0;
          write_complete = 1'b1;
          if (wr_idx < N_WORDS) begin
            if (address !== exp_addr(wr_idx)) wr_errs++;
            if (data_in !== exp_q[wr_idx]) wr_errs++;
          end else begin
            wr_errs++;
          end
          if (wr_idx == 0 && (error || err_count != '0 || fail_addr != '0)) clr_errs++;
          mem[address] = data_in;
          wr_idx++;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        write_complete = 1'b1;
      end

      if (req_read) begin
        if (rd_mode != RD_HANG) begin
          if (rd_busy == 0) rd_lat = $urandom_range(1, 6);
          rd_busy++;
          if (rd_busy >= rd_lat) begin
            rd_busy = 0;
            data_valid = 1'b1;
            if (rd_idx >= N_WORDS || address !== exp_addr(rd_idx)) rd_errs++;
            if (rd_mode == RD_ZERO) data_out = '0;
            else data_out = mem[address] ^ ((rd_mode == RD_FLIP && address == corrupt_addr) ? 32'h1 : 32'h0);
            rd_idx++;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        data_valid = 1'b1;
        data_out   = $urandom;
      end
    end
  end

  // Driver tasks
  task automatic start_press(input bit hold);
    @(negedge clk);
    button = 1'b1;
    for (int i = 0; i < 10 && !led[0]; i++) @(negedge clk);
    check_eq("run_started", led[0], 1);
    if (!hold) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      button = 1'b0;
    end
    mode = 2'($urandom);
  endtask

  task automatic wait_done(output int rd_hi);
    rd_hi = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (req_read) rd_hi++;
    end
    check_eq("done_reached", done, 1);
  endtask

  task automatic check_result(input string tag);
    check_eq({tag, "_error"}, error, exp_err);
    check_eq({tag, "_err_count"}, err_count, exp_cnt);
    check_eq({tag, "_fail_addr"}, fail_addr, exp_fail);
    check_eq({tag, "_led"}, led, {(LED_W-3)'(exp_cnt), exp_err, 1'b1, 1'b0});
    check_eq({tag, "_writes"}, wr_idx, N_WORDS);
    check_eq({tag, "_reads"}, rd_idx, N_WORDS);
    check_eq({tag, "_wr_data"}, wr_errs, 0);
    check_eq({tag, "_rd_addr"}, rd_errs, 0);
    check_eq({tag, "_protocol"}, proto_errs, 0);
    check_eq({tag, "_start_clear"}, clr_errs, 0);
  endtask

  task automatic full_run(input string tag, input logic [1:0] m, input int rdm);
    int rd_hi;
    plan_run(m, rdm);
    start_press(1'b0);
    wait_done(rd_hi);
    check_result(tag);
  endtask

  // Main sequence
  initial begin : main_seq
    int rd_hi;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_address", address, START_ADDR);
    check_eq("rst_reqs", {req_read, req_write}, 0);
    check_eq("rst_data_in", data_in, 0);
    check_eq("rst_flags", {done, error}, 0);
    check_eq("rst_counts", {err_count, fail_addr}, 0);
    check_eq("rst_led", led, 0);
    check_eq("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    full_run("addr_clean", MODE_ADDR, RD_OK);
    full_run("lfsr_flip", MODE_LFSR, RD_FLIP);
    full_run("walk_zero_sat", MODE_WALK, RD_ZERO);
    full_run("alt_zero", MODE_ALT, RD_ZERO);

    // Button held through a whole run: exactly one run, DONE is held.
    plan_run(2'($urandom), RD_FLIP);
    start_press(1'b1);
    wait_done(rd_hi);
    repeat (10) @(negedge clk);
    check_eq("hold_done_stays", done, 1);
    check_result("hold");
    button = 1'b0;
    repeat (3) @(negedge clk);

    // Second press during READ is ignored.
    plan_run(2'($urandom), RD_FLIP);
    start_press(1'b0);
    for (int i = 0; i < 2000 && !req_read; i++) @(negedge clk);
    check_eq("reached_read", req_read, 1);
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    wait_done(rd_hi);
    check_result("press_in_read");

`ifdef TIMEOUT_EN
    // Read that never completes: watchdog ends the run.
    plan_run(MODE_ADDR, RD_HANG);
    start_press(1'b0);
    wait_done(rd_hi);
    check_eq("tmo_req_read_cycles", rd_hi, 16);
    check_eq("tmo_flag", timeout, 1);
    check_eq("tmo_error", error, 1);
    check_eq("tmo_err_count", err_count, 0);
    check_eq("tmo_fail_addr", fail_addr, START_ADDR);
    check_eq("tmo_req_read", req_read, 0);
`endif

    // Reset in the middle of the write at the sixth address.
    plan_run(MODE_ADDR, RD_OK);
    start_press(1'b0);
    for (int i = 0; i < 2000 && !(req_write && address == exp_addr(5)); i++) @(negedge clk);
    check_eq("mid_write_addr", address, exp_addr(5));
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_reqs", {req_read, req_write}, 0);
    check_eq("midrst_address", address, START_ADDR);
    check_eq("midrst_state", dbg_state, IDLE);
    check_eq("midrst_led", led, 0);
    check_eq("midrst_data_in", data_in, 0);
    rst = 1'b0;
    @(negedge clk);
    spur_req++;
    repeat (3) @(negedge clk);
    check_eq("spur_wc_state", dbg_state, IDLE);
    check_eq("spur_wc_address", address, START_ADDR);
    check_eq("spur_wc_reqs", {req_read, req_write, done}, 0);

    // Normal operation after reset.
    full_run("after_reset", MODE_LFSR, RD_OK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_test_driver.md
Name: mem_test_driver

Overview:
Parametrised SDRAM traffic generator and self-checker that sits on the controller's user side in place of the fixed-pattern driver. On a button press it writes a selectable pattern over a configurable address window, reads the window back, and compares every word. It reports progress, a sticky error flag, a saturating error count and the first failing address on outputs and LEDs. All logic runs on the controller's user clock.

Parameters:
ADDR_W, 24, width of the word address to the controller
DATA_W, 32, width of the user data bus
START_ADDR, 0, first address tested
END_ADDR, 24'h00FFFF, last address tested (inclusive); must be >= START_ADDR
ADDR_STEP, 1, address increment per transaction
ERR_W, 16, width of the saturating error counter
LED_W, 8, width of the LED output; must be >= 4
TIMEOUT_CYCLES, 1024, watchdog limit (TIMEOUT_EN builds only)

Ports:
clk  in  1  user clock, same clock as the controller user side
rst  in  1  synchronous, active-high reset
button  in  1  asynchronous start request, active high
mode  in  2  pattern select, sampled at start: 0 = address, 1 = LFSR, 2 = walking-one, 3 = all-ones/zeros alternating
address  out  ADDR_W  transaction address
req_read  out  1  read request; level, held until data_valid
req_write  out  1  write request; level, held until write_complete
data_in  out  DATA_W  write data to the controller
data_out  in  DATA_W  read data from the controller
data_valid  in  1  one-cycle pulse: read data valid
write_complete  in  1  one-cycle pulse: write accepted
done  out  1  high in DONE
error  out  1  sticky mismatch (or timeout) flag
err_count  out  ERR_W  mismatch count, saturates at all-ones
fail_addr  out  ADDR_W  address of the first mismatch
led  out  LED_W  {err_count[LED_W-4:0], error, done, running}

Behaviour:
- Reset: state IDLE. address=START_ADDR. req_read=0, req_write=0, data_in=0, done=0, error=0, err_count=0, fail_addr=0, led=0.
- button passes through a 2-flop synchroniser. A rising edge of the synchronised signal is a start. It is honoured only in IDLE or DONE and ignored elsewhere.
- On start:
  - mode is latched.
  - error, err_count and fail_addr are cleared.
  - address is set to START_ADDR and the LFSR is set to the seed 32'h0000_0001.
  - The block enters WRITE.
- WRITE:
  - req_write=1 and data_in=pattern(address).
  - On write_complete, req_write drops on the same edge and the block goes to WGAP.
- WGAP: one idle cycle.
  - If last, address=START_ADDR, the LFSR is re-seeded, and the block goes to READ.
  - Otherwise, address += ADDR_STEP, the LFSR advances, and the block goes to WRITE.
- READ:
  - req_read=1.
  - On data_valid, req_read drops and data_out is registered against pattern(address).
  - On mismatch: error=1, err_count increments (saturating), and fail_addr is loaded only if error was previously 0.
  - The block goes to RGAP.
- RGAP: one idle cycle. Advance as in WGAP. If last, go to DONE.
- DONE: done=1. Hold all outputs until the next start or reset.
- last is true when address + ADDR_STEP > END_ADDR, computed in ADDR_W+1 bits. This prevents wrap at the top of the address space. START_ADDR == END_ADDR gives exactly one write and one read.
- Patterns:
  - Address mode: address zero-extended or truncated to DATA_W.
  - LFSR mode: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1. The value is replicated or truncated to DATA_W.
  - Walking-one mode: 1 << (address mod DATA_W).
  - Alternating mode: all-ones when address[0]=0, else zero.
- Completion pulses that do not match the current state are ignored: write_complete outside WRITE, data_valid outside READ. If both arrive together, only the one matching the state is used.
- req_read and req_write are never high together. address and data_in are stable while a request is high.
- rst asserted mid-transaction drops both requests at the next edge and returns all outputs to reset values.
- running = the state is not IDLE and not DONE.

Optional Feature:
TIMEOUT_EN
- Defined: a counter runs while req_read or req_write is high and clears on each state change. When it reaches TIMEOUT_CYCLES:
  - the request drops and error=1;
  - fail_addr is loaded if it is the first error; err_count is unchanged;
  - the block goes to DONE;
  - an extra output, timeout (1 bit, reset 0, sticky until the next start), is set.
- Not defined: the block waits indefinitely and the timeout port is absent.

Decomposition:
- Package mem_test_pkg holds:
  - the state enum (IDLE, WRITE, WGAP, READ, RGAP, DONE);
  - the mode encodings;
  - the LFSR seed and tap constants.
- One sub-module, mem_test_pattern: combinational pattern(address, lfsr, mode) plus the registered LFSR step. It is shared by the write and compare paths so both generate identical data.

Test Plan:
- Address mode, window 0..3, controller model with 3-cycle write and 5-cycle read latency -> 4 writes with data 0,1,2,3, then 4 reads; done=1, error=0, led=8'b0000_0010.
- LFSR mode, window 0x10..0x1F, model corrupts bit 0 at address 0x13 -> error=1, err_count=1, fail_addr=0x13, led[2]=1.
- Walking-one mode, model returns 0 for every read, ERR_W=4, window of 20 words -> err_count saturates at 4'hF.
- Button held high through a complete run, and a second press while in READ -> exactly one run; second press ignored. A press in DONE restarts with counters cleared.
- rst pulsed while req_write=1 at address 5 -> next edge: req_write=0, address=START_ADDR, state IDLE. A spurious write_complete in IDLE leaves outputs unchanged.
- TIMEOUT_EN, TIMEOUT_CYCLES=16, model never returns data_valid -> req_read drops after 16 cycles; timeout=1, error=1, done=1.
